// File: rtl/pps_pkg.sv
// Shared widths, FSM state type and the fraction-to-cycles phase conversion
// used by the PPS generator.
package pps_pkg;

  localparam int unsigned SEC_W  = 40;
  localparam int unsigned FRAC_W = 32;

  typedef enum logic {
    UNSYNCED = 1'b0,
    SYNCED   = 1'b1
  } pps_state_e;

  // Scale a binary fraction of a second (frac / 2^FRAC_W) into whole clock
  // cycles. The product is formed at 64 bits and the fraction is truncated.
  function automatic logic [63:0] frac_to_cycles(input logic [FRAC_W-1:0] frac,
                                                 input logic [63:0]       clk_freq);
    return (64'(frac) * clk_freq) >> FRAC_W;
  endfunction

endpackage

// File: rtl/pps_pulse_stretcher.sv
// Stretches a single-cycle start strobe into a pulse exactly PULSE_WIDTH
// cycles wide. A start while a pulse is already high restarts the width.
module pps_pulse_stretcher
  import pps_pkg::*;
#(
  parameter int unsigned PULSE_WIDTH = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  output logic o_pulse
);

  localparam int unsigned WC_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;

  logic [WC_W-1:0] r_width;
  logic            r_pulse;

  // Raise the pulse on start, then count the remaining high cycles down to zero
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse <= 1'b0;
      r_width <= '0;
    end else if (i_start) begin
      r_pulse <= 1'b1;
      r_width <= WC_W'(PULSE_WIDTH - 1);
    end else if (r_pulse) begin
      if (r_width == '0) begin
        r_pulse <= 1'b0;
      end else begin
        r_width <= r_width - WC_W'(1);
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/pps_generator.sv
// One-pulse-per-second generator phase-locked to decoded timestamps. A
// sub-second cycle counter is re-phased on every accepted timestamp; each
// natural wrap of that counter emits a fixed-width pulse and bumps the pulse
// count. Inconsistent or out-of-range timestamps raise pps_error.
module pps_generator
  import pps_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned PULSE_WIDTH  = 10_000_000,
  parameter int unsigned LATENCY_COMP = 2,
  parameter int unsigned ERR_THRESH   = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              timestamp_valid,
  input  logic [SEC_W-1:0]  seconds_since_2000,
  input  logic [FRAC_W-1:0] subseconds,
  input  logic              timestamp_ready,
  output logic              pps_pulse,
  output logic [31:0]       pps_counter,
  output logic              pps_error
);

  localparam int unsigned     PH_W   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(CLK_FREQ - 1);

  pps_state_e       r_state;
  pps_state_e       w_state_next;
  logic [PH_W-1:0]  r_phase;
  logic [SEC_W-1:0] r_exp_sec;
  logic [31:0]      r_pps_count;
  logic             r_err;

  logic             w_accept;
  logic             w_wrap;
  logic             w_start;
  logic [63:0]      w_raw_phase;
  logic [PH_W-1:0]  w_phase_load;
  logic [PH_W-1:0]  w_phase_next;
  logic [SEC_W-1:0] w_load_sec;
  logic [SEC_W-1:0] w_sec_now;
  logic [SEC_W-1:0] w_sec_diff;
  logic [31:0]      w_ph_diff;
  logic [31:0]      w_ph_circ;
  logic             w_range_bad;
  logic             w_sec_bad;
  logic             w_ph_bad;
  logic             w_err_next;

  assign w_accept     = timestamp_valid && timestamp_ready;
  assign w_wrap       = (r_phase == PH_MAX);
  assign w_phase_next = w_wrap ? '0 : r_phase + PH_W'(1);
  // A load on the wrap edge re-phases the counter and suppresses that pulse.
  assign w_start      = (r_state == SYNCED) && !w_accept && w_wrap;

  // Convert the timestamp fraction into a cycle phase; compensation that
  // pushes past the end of the second carries into the next second.
  // NOTE: every combinational output gets a default before any condition so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_raw_phase  = frac_to_cycles(subseconds, 64'(CLK_FREQ)) + 64'(LATENCY_COMP);
    w_phase_load = PH_W'(w_raw_phase);
    w_load_sec   = seconds_since_2000;
    if (w_raw_phase >= 64'(CLK_FREQ)) begin
      w_phase_load = PH_W'(w_raw_phase - 64'(CLK_FREQ));
      w_load_sec   = seconds_since_2000 + SEC_W'(1);
    end
  end

  // Compare the incoming timestamp against where the free-running counter
  // would land on this edge (second and circular phase).
  always_comb begin
    w_sec_now   = w_wrap ? r_exp_sec : r_exp_sec - SEC_W'(1);
    w_sec_diff  = (w_load_sec >= w_sec_now) ? w_load_sec - w_sec_now
                                            : w_sec_now - w_load_sec;
    w_ph_diff   = (w_phase_load >= w_phase_next) ? 32'(w_phase_load - w_phase_next)
                                                 : 32'(w_phase_next - w_phase_load);
    w_ph_circ   = (w_ph_diff > CLK_FREQ / 2) ? CLK_FREQ - w_ph_diff : w_ph_diff;
    w_range_bad = |seconds_since_2000[SEC_W-1:32];
    w_sec_bad   = (w_sec_diff > SEC_W'(1));
    w_ph_bad    = (w_ph_circ > ERR_THRESH);
    w_err_next  = w_range_bad || ((r_state == SYNCED) && (w_sec_bad || w_ph_bad));
  end

  // Sync state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= UNSYNCED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Any accepted timestamp leaves the generator synced
  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      w_state_next = SYNCED;
    end
  end

  // Phase counter, expected second, pulse count and fault flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= '0;
      r_exp_sec   <= '0;
      r_pps_count <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_phase   <= w_phase_load;
      r_exp_sec <= w_load_sec + SEC_W'(1);
      r_err     <= w_err_next;
    end else if (r_state == SYNCED) begin
      r_phase <= w_phase_next;
      if (w_wrap) begin
        r_pps_count <= r_pps_count + 32'd1;
        r_exp_sec   <= r_exp_sec + SEC_W'(1);
      end
    end
  end

  pps_pulse_stretcher #(
    .PULSE_WIDTH(PULSE_WIDTH)
  ) u_stretcher (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(w_start),
    .o_pulse(pps_pulse)
  );

  assign pps_counter = r_pps_count;
  assign pps_error   = r_err;

endmodule

// File: tb/tb_pps_generator.sv
// Directed bench for pps_generator. Stimulus pushes the expected pulse
// (rise edge, count, error flag, width) into a queue; a monitor pops and
// compares on every rising edge of pps_pulse.
module tb_pps_generator;

  localparam int unsigned CF = 1000;
  localparam int unsigned PW = 100;
  localparam int unsigned LC = 2;
  localparam int unsigned ET = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ts_valid = 1'b0;
  logic        ts_ready = 1'b0;
  logic [39:0] ts_sec = '0;
  logic [31:0] ts_frac = '0;
  logic        pps_pulse;
  logic [31:0] pps_counter;
  logic        pps_error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int at;
    int cnt;
    bit err;
    int width;
  } pulse_t;

  pulse_t exp_q[$];

  pps_generator #(
    .CLK_FREQ    (CF),
    .PULSE_WIDTH (PW),
    .LATENCY_COMP(LC),
    .ERR_THRESH  (ET)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .timestamp_valid   (ts_valid),
    .seconds_since_2000(ts_sec),
    .subseconds        (ts_frac),
    .timestamp_ready   (ts_ready),
    .pps_pulse         (pps_pulse),
    .pps_counter       (pps_counter),
    .pps_error         (pps_error)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of posedges so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input int at, input int cnt, input bit err, input int width);
    pulse_t p;
    p.at = at;
    p.cnt = cnt;
    p.err = err;
    p.width = width;
    exp_q.push_back(p);
  endtask

  // Accepting edge is 'at'; returns at the negedge following it.
  task automatic send_at(input int at, input logic [39:0] s, input logic [31:0] f,
                         input logic rdy);
    while (cyc < at - 1) @(negedge clk);
    ts_sec   = s;
    ts_frac  = f;
    ts_valid = 1'b1;
    ts_ready = rdy;
    @(negedge clk);
    ts_valid = 1'b0;
    ts_ready = 1'b0;
  endtask

  // Monitor
  bit     mon_prev = 1'b0;
  int     mon_hi = 0;
  pulse_t mon_cur;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (pps_pulse === 1'b1 && !mon_prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: rise at edge %0d, none expected", cyc);
          mon_cur.width = 0;
        end else begin
          mon_cur = exp_q.pop_front();
          check("pulse_rise_edge", 64'(cyc), 64'(mon_cur.at));
          check("pulse_counter", 64'(pps_counter), 64'(mon_cur.cnt));
          check("pulse_error", 64'(pps_error), 64'(mon_cur.err));
        end
        mon_hi = 1;
      end else if (pps_pulse === 1'b1) begin
        mon_hi++;
      end else if (mon_prev) begin
        if (mon_cur.width != 0) check("pulse_width", 64'(mon_hi), 64'(mon_cur.width));
      end
      mon_prev = (pps_pulse === 1'b1);
    end
  end

  int e, a1, p4, p5, p6, p7, p8, p9, p10;

  initial begin : stimulus
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pulse", 64'(pps_pulse), 0);
    check("rst_counter", 64'(pps_counter), 0);
    check("rst_error", 64'(pps_error), 0);
    rst_n = 1'b1;

    // Initial sync: 0.5 s -> 500 + 2 = 502, wrap 498 edges later.
    a1 = 100;
    send_at(a1, 40'd1000, 32'h8000_0000, 1'b1);
    check("sync_error", 64'(pps_error), 0);
    for (int k = 0; k < 4; k++) expect_pulse(a1 + 498 + 1000 * k, k + 1, 1'b0, PW);
    p4 = a1 + 3498;

    // Small correction: counter would be at 300, timestamp loads 305.
    e = p4 + 300;
    send_at(e, 40'd1004, 32'd1301375091, 1'b1);
    check("small_corr_error", 64'(pps_error), 0);
    p5 = e + 695;
    expect_pulse(p5, 5, 1'b0, PW);

    // Large jump in seconds: loads phase 2, next wrap 998 edges later.
    e = p5 + 200;
    send_at(e, 40'd4600, 32'd0, 1'b1);
    check("jump_error", 64'(pps_error), 1);
    p6 = e + 998;
    expect_pulse(p6, 6, 1'b1, PW);

    // Consistent timestamp (second 4601, phase 400) clears the flag.
    e = p6 + 400;
    send_at(e, 40'd4601, 32'd1709396984, 1'b1);
    check("clear_error", 64'(pps_error), 0);
    p7 = e + 600;
    expect_pulse(p7, 7, 1'b0, PW);

    // Exact fractions; neither load produces a pulse of its own.
    e = p7 + 200;
    send_at(e, 40'd5000, 32'd0, 1'b1);
    check("frac0_error", 64'(pps_error), 1);
    e = e + 500;
    send_at(e, 40'd5001, 32'h1999_9999, 1'b1);
    check("frac_tenth_error", 64'(pps_error), 1);
    p8 = e + 899;
    expect_pulse(p8, 8, 1'b1, PW);

    // Realign (second 5002, phase 200), then an unqualified strobe.
    send_at(p8 + 200, 40'd5002, 32'd850403525, 1'b1);
    check("realign_error", 64'(pps_error), 0);
    send_at(p8 + 250, 40'd4000, 32'd0, 1'b0);
    check("not_ready_error", 64'(pps_error), 0);

    // Out-of-range seconds.
    e = p8 + 300;
    send_at(e, 40'hFF_FFFF_FF00, 32'd0, 1'b1);
    check("range_error", 64'(pps_error), 1);
    p9 = e + 998;
    expect_pulse(p9, 9, 1'b1, 0);
    send_at(p8 + 400, 40'd5000, 32'h8000_0000, 1'b0);
    check("not_ready_error_hold", 64'(pps_error), 1);

    // Reset in the middle of pulse 9.
    while (cyc < p9 + 50) @(negedge clk);
    check("pulse_before_reset", 64'(pps_pulse), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pulse", 64'(pps_pulse), 0);
    check("mid_rst_counter", 64'(pps_counter), 0);
    check("mid_rst_error", 64'(pps_error), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2500) @(negedge clk);
    check("idle_counter", 64'(pps_counter), 0);

    // Resync after reset: counting restarts at 1.
    e = cyc + 10;
    send_at(e, 40'd10, 32'd0, 1'b1);
    check("resync_error", 64'(pps_error), 0);
    p10 = e + 998;
    expect_pulse(p10, 1, 1'b0, PW);

    while (cyc < p10 + 150) @(negedge clk);
    check("pending_pulses", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
